// File: rtl/moore_rr_arbiter_pkg.sv
// moore_arb_pkg: shared types and constants for the moore_rr_arbiter slice.
//   arb_state_t - arbiter FSM state (idle / clear pulse / serving owner)
//   STATS_W     - width of the optional statistics counters
//   idx_width   - owner-index width for a given requester count (minimum 1)
package moore_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CLEAR = 2'd1,
        ARB_SERVE = 2'd2
    } arb_state_t;

    localparam int unsigned STATS_W = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/moore_rr_arbiter_if.sv
// moore_rr_arbiter_if: requester streams plus the shared Moore FSM hookup.
//   req, x_in   - per-requester request level and serial bit
//   gnt         - one-hot grant (registered)
//   fsm_x       - serial bit steered to the shared FSM
//   fsm_reset   - clear pulse to the shared FSM (registered)
//   fsm_outp    - shared FSM output
//   outp, outp_valid, outp_owner - relayed FSM output tagged with its owner
// Modports: slave = arbiter side, master = requester/FSM side.
interface moore_rr_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned IDX_W = moore_arb_pkg::idx_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] x_in;
    logic [N_REQ-1:0] gnt;
    logic             fsm_x;
    logic             fsm_reset;
    logic             fsm_outp;
    logic             outp;
    logic             outp_valid;
    logic [IDX_W-1:0] outp_owner;

    modport slave (
        input  req, x_in, fsm_outp,
        output gnt, fsm_x, fsm_reset, outp, outp_valid, outp_owner
    );

    modport master (
        output req, x_in, fsm_outp,
        input  gnt, fsm_x, fsm_reset, outp, outp_valid, outp_owner
    );

endinterface

// File: rtl/moore_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     - request vector
//   start   - index searched first; search continues upward modulo N_REQ
//   exclude - mask of requesters that may not be picked
//   found   - some non-excluded requester is active
//   idx     - first such requester in rotation order
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic [N_REQ-1:0] exclude,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0]   cand;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate the candidates so bit 0 is the start position; the doubled
    // vector makes the wrap-around a plain right shift.
    assign cand = req & ~exclude;
    assign dbl  = {cand, cand} >> start;
    assign rot  = dbl[N_REQ-1:0];

    always_comb begin
        logic [IDX_W:0] sum;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, start} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(N_REQ)) begin
                    sum = sum - (IDX_W+1)'(N_REQ);
                end
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/moore_rr_arbiter.sv
// moore_rr_arbiter: round-robin owner of one shared serial-input Moore FSM.
//   clk, reset    - clock and synchronous active-high reset
//   bus (slave)   - requester streams in, grant/clear/serial bit out,
//                   FSM output relayed with owner tag
// Optional macro MOORE_ARB_STATS_EN adds grant_total / preempt_total,
// saturating counts of clear entries and burst-limit handovers.
module moore_rr_arbiter
    import moore_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    moore_rr_arbiter_if.slave    bus
`ifdef MOORE_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]   grant_total,
    output logic [STATS_W-1:0]   preempt_total
`endif
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
    localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]  burst_q, burst_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             fsm_reset_q, fsm_reset_d;
    logic             preempt_go;

    logic [N_REQ-1:0] owner_oh;
    logic [IDX_W-1:0] owner_nxt;
    logic             req_own;
    logic             serving;
    logic             at_limit;
    logic [IDX_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_excl;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign owner_oh  = N_REQ'(1) << owner_q;
    assign owner_nxt = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign req_own   = |(bus.req & owner_oh);
    assign serving   = (state_q == ARB_SERVE);
    assign at_limit  = (burst_q >= BC_W'(MAX_BURST - 1));

    // One picker serves both cases: from rr_ptr over everyone when idle,
    // from owner+1 over the others when looking for a preemptor.
    assign pick_start = (state_q == ARB_IDLE) ? rr_ptr_q : owner_nxt;
    assign pick_excl  = (state_q == ARB_IDLE) ? '0 : owner_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .start   (pick_start),
        .exclude (pick_excl),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign preempt_go = serving && req_own && at_limit && pick_found;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        gnt_d       = gnt_q;
        fsm_reset_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (|bus.req) begin
                    owner_d     = pick_idx;
                    state_d     = ARB_CLEAR;
                    fsm_reset_d = 1'b1;
                end
            end
            ARB_CLEAR: begin
                state_d = ARB_SERVE;
                gnt_d   = owner_oh;
                burst_d = '0;
            end
            ARB_SERVE: begin
                if (!req_own) begin
                    // Drop wins over the burst limit.
                    state_d  = ARB_IDLE;
                    rr_ptr_d = owner_nxt;
                    gnt_d    = '0;
                end else if (preempt_go) begin
                    rr_ptr_d    = owner_nxt;
                    owner_d     = pick_idx;
                    state_d     = ARB_CLEAR;
                    fsm_reset_d = 1'b1;
                    gnt_d       = '0;
                end else if (burst_q != BC_W'(MAX_BURST)) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            gnt_q       <= '0;
            fsm_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            gnt_q       <= gnt_d;
            fsm_reset_q <= fsm_reset_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.fsm_reset  = fsm_reset_q;
    assign bus.fsm_x      = serving & req_own & (|(bus.x_in & owner_oh));
    assign bus.outp       = bus.fsm_outp;
    assign bus.outp_valid = serving;
    assign bus.outp_owner = serving ? owner_q : '0;

`ifdef MOORE_ARB_STATS_EN
    // fsm_reset_d marks every entry into CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_total   <= '0;
            preempt_total <= '0;
        end else begin
            if (fsm_reset_d && (grant_total != '1)) begin
                grant_total <= grant_total + 1'b1;
            end
            if (preempt_go && (preempt_total != '1)) begin
                preempt_total <= preempt_total + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// tb_moore_rr_arbiter: self-checking bench for moore_rr_arbiter
// (N_REQ=4, MAX_BURST=8). Build with MOORE_ARB_STATS_EN to include the
// statistics counters in the checks.
module tb_moore_rr_arbiter;
    import moore_arb_pkg::*;

    localparam int N  = 4;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    moore_rr_arbiter_if #(.N_REQ(N)) bus ();

`ifdef MOORE_ARB_STATS_EN
    logic [15:0] grant_total;
    logic [15:0] preempt_total;
`endif

    moore_rr_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus)
`ifdef MOORE_ARB_STATS_EN
        ,
        .grant_total   (grant_total),
        .preempt_total (preempt_total)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner holds the grant when 'has'; 'clr' marks the clear cycle;
    // served counts SERVE cycles already completed in this grant.
    typedef struct {
        int owner;
        bit has;
        bit clr;
        int served;
        int ptr;
        int gtot;
        int ptot;
    } m_t;

    m_t m;

    function automatic bit bitat(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int pick(input int start, input logic [N-1:0] r, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && bitat(r, i)) return i;
        end
        return -1;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic m_t m_next(input m_t s, input bit rst, input logic [N-1:0] rq);
        m_t n;
        int p;
        int served_now;
        n = s;
        if (rst) begin
            n.owner = 0; n.has = 0; n.clr = 0; n.served = 0;
            n.ptr = 0; n.gtot = 0; n.ptot = 0;
            return n;
        end
        if (!s.has) begin
            p = pick(s.ptr, rq, -1);
            if (p >= 0) begin
                n.has = 1; n.clr = 1; n.owner = p;
                n.gtot = sat16(s.gtot + 1);
            end
        end else if (s.clr) begin
            n.clr = 0;
            n.served = 0;
        end else begin
            served_now = s.served + 1;
            if (!bitat(rq, s.owner)) begin
                n.has = 0;
                n.ptr = (s.owner + 1) % N;
            end else begin
                p = (served_now >= MB) ? pick((s.owner + 1) % N, rq, s.owner) : -1;
                if (p >= 0) begin
                    n.ptr = (s.owner + 1) % N;
                    n.owner = p;
                    n.clr = 1;
                    n.served = 0;
                    n.gtot = sat16(s.gtot + 1);
                    n.ptot = sat16(s.ptot + 1);
                end else begin
                    n.served = (served_now > MB) ? MB : served_now;
                end
            end
        end
        return n;
    endfunction

    // {gnt, fsm_x, fsm_reset, outp, outp_valid, outp_owner}
    function automatic logic [9:0] model_out(input m_t s, input logic [N-1:0] rq,
                                             input logic [N-1:0] x, input logic fo);
        bit serv;
        logic [N-1:0] oh;
        logic fx;
        serv = s.has && !s.clr;
        oh = serv ? (N'(1) << s.owner) : '0;
        fx = serv && bitat(rq, s.owner) && bitat(x, s.owner);
        return {oh, fx, s.has && s.clr, fo, serv, serv ? 2'(s.owner) : 2'b00};
    endfunction

    always @(posedge clk) m <= m_next(m, reset, bus.req);

    function automatic logic [9:0] dut_out();
        return {bus.gnt, bus.fsm_x, bus.fsm_reset, bus.outp, bus.outp_valid, bus.outp_owner};
    endfunction

    // Apply inputs half a cycle before the next edge, settle, return.
    task automatic drive(input bit r, input logic [N-1:0] rq, input logic [N-1:0] x, input bit fo);
        @(negedge clk);
        reset = r;
        bus.req = rq;
        bus.x_in = x;
        bus.fsm_outp = fo;
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit       rst;
        logic [3:0] req;
        logic [3:0] x;
        bit       fo;
        logic [3:0] gnt;
        bit       fx;
        bit       frst;
        bit       val;
        logic [1:0] own;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [N-1:0] rq;
        logic [3:0] eg;
        bit ef;

        reset = 1'b1;
        bus.req = '0;
        bus.x_in = '0;
        bus.fsm_outp = 1'b0;

        //            rst req      x        fo  gnt      fx frst val own
        tbl[0]  = '{1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 0, 2'd0};
        tbl[1]  = '{0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 0, 2'd0};
        tbl[2]  = '{0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 1, 0, 2'd0};
        tbl[3]  = '{0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 0, 1, 2'd2};
        tbl[4]  = '{0, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, 1, 2'd2};
        tbl[5]  = '{0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 0, 1, 2'd2};
        tbl[6]  = '{0, 4'b0000, 4'b0100, 0, 4'b0100, 0, 0, 1, 2'd2};
        tbl[7]  = '{0, 4'b1011, 4'b1111, 1, 4'b0000, 0, 0, 0, 2'd0};
        tbl[8]  = '{0, 4'b1011, 4'b1111, 0, 4'b0000, 0, 1, 0, 2'd0};
        tbl[9]  = '{0, 4'b1011, 4'b1000, 1, 4'b1000, 1, 0, 1, 2'd3};
        tbl[10] = '{0, 4'b0011, 4'b1000, 0, 4'b1000, 0, 0, 1, 2'd3};
        tbl[11] = '{0, 4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 0, 2'd0};
        tbl[12] = '{0, 4'b0011, 4'b0001, 0, 4'b0000, 0, 1, 0, 2'd0};
        tbl[13] = '{0, 4'b0011, 4'b0001, 1, 4'b0001, 1, 0, 1, 2'd0};

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].x, tbl[i].fo);
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({tbl[i].gnt, tbl[i].fx, tbl[i].frst, tbl[i].fo, tbl[i].val, tbl[i].own}));
        end

        // Burst limit: two requesters held, 8 SERVE cycles each, one CLEAR between.
        drive(1, '0, '0, 0);
        for (int c = 0; c < 38; c++) begin
            drive(0, 4'b0011, 4'($urandom_range(15)), 0);
            if (c == 0) begin
                eg = 4'b0000; ef = 0;
            end else if ((c - 1) % 9 == 0) begin
                eg = 4'b0000; ef = 1;
            end else begin
                eg = (((c - 2) / 9) % 2 == 0) ? 4'b0001 : 4'b0010; ef = 0;
            end
            chk($sformatf("burst c%0d", c), 32'({bus.gnt, bus.fsm_reset}), 32'({eg, ef}));
        end

        // Lone requester saturates, then a late requester preempts at once.
        drive(1, '0, '0, 0);
        for (int c = 0; c < 23; c++) begin
            drive(0, (c < 20) ? 4'b1000 : 4'b1001, 4'b1111, 0);
            if (c == 0) begin
                eg = 4'b0000; ef = 0;
            end else if (c == 1 || c == 21) begin
                eg = 4'b0000; ef = 1;
            end else if (c == 22) begin
                eg = 4'b0001; ef = 0;
            end else begin
                eg = 4'b1000; ef = 0;
            end
            chk($sformatf("lone c%0d", c), 32'({bus.gnt, bus.fsm_reset}), 32'({eg, ef}));
        end

        // Owner drops exactly on its last allowed cycle: IDLE, not CLEAR.
        drive(1, '0, '0, 0);
        for (int c = 0; c < 13; c++) begin
            drive(0, (c < 9) ? 4'b0011 : 4'b0010, 4'b1111, 0);
            if (c == 8)  chk("drop pre",  32'({bus.gnt, bus.fsm_x, bus.fsm_reset, bus.outp_valid}), 32'({4'b0001, 1'b1, 1'b0, 1'b1}));
            if (c == 9)  chk("drop cyc",  32'({bus.gnt, bus.fsm_x, bus.fsm_reset, bus.outp_valid}), 32'({4'b0001, 1'b0, 1'b0, 1'b1}));
            if (c == 10) chk("drop idle", 32'({bus.gnt, bus.fsm_x, bus.fsm_reset, bus.outp_valid}), 32'({4'b0000, 1'b0, 1'b0, 1'b0}));
            if (c == 11) chk("drop clr",  32'({bus.gnt, bus.fsm_reset}), 32'({4'b0000, 1'b1}));
            if (c == 12) chk("drop next", 32'({bus.gnt, bus.outp_owner}), 32'({4'b0010, 2'd1}));
        end

        // Reset while serving owner 1.
        drive(1, 4'b0010, 4'b0010, 0);
        drive(0, 4'b0000, 4'b0000, 0);
        chk("rst gnt",   32'(bus.gnt), 32'(0));
        chk("rst valid", 32'({bus.outp_valid, bus.fsm_reset, bus.outp_owner}), 32'(0));
`ifdef MOORE_ARB_STATS_EN
        chk("rst grant_total",   32'(grant_total), 32'(0));
        chk("rst preempt_total", 32'(preempt_total), 32'(0));
`endif

        // Randomized streams against the reference model.
        drive(1, '0, '0, 0);
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) rq = rq ^ (N'(1) << b);
            end
            drive(($urandom_range(199) == 0), rq, N'($urandom_range(15)), 1'($urandom_range(1)));
            chk($sformatf("rand c%0d", c), 32'(dut_out()),
                32'(model_out(m, bus.req, bus.x_in, bus.fsm_outp)));
`ifdef MOORE_ARB_STATS_EN
            chk("rand grant_total",   32'(grant_total), 32'(m.gtot));
            chk("rand preempt_total", 32'(preempt_total), 32'(m.ptot));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
